// File: rtl/zxbus_ioctl_pkg.sv
// zxbus_ioctl_pkg: shared definitions for the Z80 I/O cycle controller.
//   - FSM state encoding (also exported on the debug state port)
//   - AY port decode constants (#FFFD / #BFFD) and the config nibble
//   - YM {BDIR,BC1} bus encodings and a chip-select helper
package zxbus_ioctl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    STRB     = 3'd2,
    HOLD     = 3'd3,
    READ     = 3'd4,
    WAIT_END = 3'd5
  } state_e;

  // AY ports: A15=1, A1=0; A14 selects #FFFD (address) or #BFFD (data)
  localparam logic       A15_AY     = 1'b1;
  localparam logic       A1_AY      = 1'b0;
  localparam logic       A14_ADDR   = 1'b1;
  // Writes to #FFFD with this upper nibble belong to the config block
  localparam logic [3:0] CFG_NIBBLE = 4'hF;

  // YM bus control, packed as {bdir, bc1}
  localparam logic [1:0] YM_BUS_IDLE  = 2'b00;
  localparam logic [1:0] YM_BUS_ADDR  = 2'b11;
  localparam logic [1:0] YM_BUS_WRITE = 2'b10;
  localparam logic [1:0] YM_BUS_READ  = 2'b01;

  // Active-low chip select pair for the YM picked by ym_sel
  function automatic logic [1:0] ym_cs_n_for(input logic sel);
    return sel ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/zxbus_ioctl_if.sv
// zxbus_ioctl_if: bus bundle around the I/O cycle controller.
//   Z80 side : iorq_n, wr_n, rd_n, m1_n (asynchronous strobes), a15/a14/a1, d
//   Config   : ym_sel, saa_sel (from config block), cfg_d, cfg_wrstb (to it)
//   Chip bus : ym_bdir, ym_bc1, ym_cs_n[1:0], saa_cs_n, saa_wr_n, saa_a0,
//              chip_d (latched write data), rd_oe
// Protocol: there is no valid/ready handshake. A Z80 I/O cycle is framed by
// iorq_n low; address and data are stable for the whole frame. The controller
// answers each frame with exactly one action: a 1-clk cfg_wrstb pulse, a timed
// chip write (CS, then strobe, then CS released), or a read held until iorq_n
// rises again.
interface zxbus_ioctl_if;
  logic       iorq_n, wr_n, rd_n, m1_n;
  logic       a15, a14, a1;
  logic [7:0] d;
  logic       ym_sel, saa_sel;
  logic [7:0] cfg_d;
  logic       cfg_wrstb;
  logic       ym_bdir, ym_bc1;
  logic [1:0] ym_cs_n;
  logic       saa_cs_n, saa_wr_n, saa_a0;
  logic [7:0] chip_d;
  logic       rd_oe;

  // Z80 / config block side
  modport master (
    output iorq_n, wr_n, rd_n, m1_n, a15, a14, a1, d, ym_sel, saa_sel,
    input  cfg_d, cfg_wrstb, ym_bdir, ym_bc1, ym_cs_n,
           saa_cs_n, saa_wr_n, saa_a0, chip_d, rd_oe
  );

  // Controller side
  modport slave (
    input  iorq_n, wr_n, rd_n, m1_n, a15, a14, a1, d, ym_sel, saa_sel,
    output cfg_d, cfg_wrstb, ym_bdir, ym_bc1, ym_cs_n,
           saa_cs_n, saa_wr_n, saa_a0, chip_d, rd_oe
  );
endinterface

// File: rtl/zxbus_ioctl_sync2.sv
// sync2: two-flop synchronizer for one asynchronous strobe.
//   clk, rst_n : clock, async active-low reset (flops reset to 1 = inactive)
//   d_i        : raw asynchronous input
//   q_o        : synchronized output
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic meta_q, sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/zxbus_ioctl.sv
// zxbus_ioctl: Z80-side I/O cycle controller for the sound card.
//   clk, rst_n : system clock (>= 4x Z80 clock), async active-low reset
//   bus        : zxbus_ioctl_if.slave (Z80 strobes/address/data, config
//                selects and config write, YM/SAA chip bus, rd_oe)
//   state_o    : current FSM state (debug)
// Parameter STRB_CYCLES (1..15): clocks the write strobe stays active.
module zxbus_ioctl
  import zxbus_ioctl_pkg::*;
#(
  parameter int unsigned STRB_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  zxbus_ioctl_if.slave  bus,
  output state_e        state_o
);

  logic iorq_s, wr_s, rd_s, m1_s;

  sync2 u_sync_iorq (.clk(clk), .rst_n(rst_n), .d_i(bus.iorq_n), .q_o(iorq_s));
  sync2 u_sync_wr   (.clk(clk), .rst_n(rst_n), .d_i(bus.wr_n),   .q_o(wr_s));
  sync2 u_sync_rd   (.clk(clk), .rst_n(rst_n), .d_i(bus.rd_n),   .q_o(rd_s));
  sync2 u_sync_m1   (.clk(clk), .rst_n(rst_n), .d_i(bus.m1_n),   .q_o(m1_s));

  state_e     state_q;
  logic [1:0] settle_q;
  logic       armed_q;
  logic [3:0] cnt_q;
  logic       tgt_saa_q, phase_addr_q;
  logic [7:0] cfg_d_q, chip_d_q;
  logic       cfg_wrstb_q, ym_bdir_q, ym_bc1_q;
  logic [1:0] ym_cs_n_q;
  logic       saa_cs_n_q, saa_wr_n_q, saa_a0_q, rd_oe_q;

  logic ay_port, io_cycle, io_wr, io_rd, cfg_hit;

  // Address/data are sampled raw: they are stable for the whole I/O cycle.
  assign ay_port  = (bus.a15 == A15_AY) && (bus.a1 == A1_AY);
  assign io_cycle = armed_q && !iorq_s && m1_s;
  assign io_wr    = io_cycle && !wr_s && ay_port;
  assign io_rd    = io_cycle && !rd_s && ay_port;
  assign cfg_hit  = (bus.a14 == A14_ADDR) && (bus.d[7:4] == CFG_NIBBLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      settle_q     <= 2'b00;
      armed_q      <= 1'b0;
      cnt_q        <= 4'd0;
      tgt_saa_q    <= 1'b0;
      phase_addr_q <= 1'b0;
      cfg_d_q      <= 8'hFF;
      chip_d_q     <= 8'h00;
      cfg_wrstb_q  <= 1'b0;
      ym_bdir_q    <= 1'b0;
      ym_bc1_q     <= 1'b0;
      ym_cs_n_q    <= 2'b11;
      saa_cs_n_q   <= 1'b1;
      saa_wr_n_q   <= 1'b1;
      saa_a0_q     <= 1'b0;
      rd_oe_q      <= 1'b0;
    end else begin
      cfg_wrstb_q <= 1'b0;

      // The synchronizers come out of reset showing "inactive" regardless of
      // the real strobe, so iorq_s is only trusted once two real samples have
      // flushed through. Arming on a trusted iorq high means a Z80 cycle that
      // straddles reset release is never executed.
      if (settle_q != 2'b11) begin
        settle_q <= {settle_q[0], 1'b1};
      end else if (iorq_s) begin
        armed_q <= 1'b1;
      end

      // Outputs are driven on the edge entering each state so that they are
      // visible for the whole state: CS across SETUP/STRB/HOLD, strobe in STRB.
      case (state_q)
        IDLE: begin
          if (io_wr) begin
            if (cfg_hit) begin
              cfg_d_q     <= bus.d;
              cfg_wrstb_q <= 1'b1;
              state_q     <= WAIT_END;
            end else begin
              chip_d_q     <= bus.d;
              phase_addr_q <= bus.a14;
              tgt_saa_q    <= bus.saa_sel;
              if (bus.saa_sel) begin
                saa_cs_n_q <= 1'b0;
                saa_a0_q   <= bus.a14;
              end else begin
                ym_cs_n_q  <= ym_cs_n_for(bus.ym_sel);
              end
              state_q <= SETUP;
            end
          end else if (io_rd) begin
            // SAA is write-only, so every decoded read goes to a YM.
            ym_cs_n_q              <= ym_cs_n_for(bus.ym_sel);
            {ym_bdir_q, ym_bc1_q}  <= YM_BUS_READ;
            rd_oe_q                <= 1'b1;
            state_q                <= READ;
          end
        end
        SETUP: begin
          cnt_q <= 4'(STRB_CYCLES - 1);
          if (tgt_saa_q) begin
            saa_wr_n_q <= 1'b0;
          end else begin
            {ym_bdir_q, ym_bc1_q} <= phase_addr_q ? YM_BUS_ADDR : YM_BUS_WRITE;
          end
          state_q <= STRB;
        end
        STRB: begin
          if (cnt_q == 4'd0) begin
            saa_wr_n_q            <= 1'b1;
            {ym_bdir_q, ym_bc1_q} <= YM_BUS_IDLE;
            state_q               <= HOLD;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        HOLD: begin
          ym_cs_n_q  <= 2'b11;
          saa_cs_n_q <= 1'b1;
          state_q    <= iorq_s ? IDLE : WAIT_END;
        end
        READ: begin
          if (iorq_s) begin
            ym_cs_n_q             <= 2'b11;
            {ym_bdir_q, ym_bc1_q} <= YM_BUS_IDLE;
            rd_oe_q               <= 1'b0;
            state_q               <= IDLE;
          end
        end
        WAIT_END: begin
          if (iorq_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cfg_d     = cfg_d_q;
  assign bus.cfg_wrstb = cfg_wrstb_q;
  assign bus.ym_bdir   = ym_bdir_q;
  assign bus.ym_bc1    = ym_bc1_q;
  assign bus.ym_cs_n   = ym_cs_n_q;
  assign bus.saa_cs_n  = saa_cs_n_q;
  assign bus.saa_wr_n  = saa_wr_n_q;
  assign bus.saa_a0    = saa_a0_q;
  assign bus.chip_d    = chip_d_q;
  assign bus.rd_oe     = rd_oe_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_zxbus_ioctl.sv
// tb_zxbus_ioctl: scoreboard bench for zxbus_ioctl. Stimulus pushes the
// expected bus event of each Z80 I/O cycle; a monitor rebuilds events from the
// DUT pins (cfg pulse, chip-select window) and compares in order.
// Event record {kind[2], cs_n[2], bus[2], data[8], cs_len[6], strb_len[6], 6'b0}
//   kind: 0 cfg write, 1 YM write, 2 SAA write, 3 YM read
module tb_zxbus_ioctl;
  import zxbus_ioctl_pkg::*;

  localparam int N = 4;
  localparam int W = 32;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_e state_dbg;
  int     tests_run = 0;
  int     tests_failed = 0;
  logic [W-1:0] exp_q[$];

  zxbus_ioctl_if bus_if ();

  zxbus_ioctl #(.STRB_CYCLES(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus_if),
    .state_o (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] mk(input logic [1:0] kind, input logic [1:0] cs,
                                      input logic [1:0] bus, input logic [7:0] data,
                                      input int cs_len, input int strb_len);
    return {kind, cs, bus, data, 6'(cs_len), 6'(strb_len), 6'b0};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cfg_d"},     32'(bus_if.cfg_d), 32'hFF);
    check({tag, "_cfg_wrstb"}, 32'(bus_if.cfg_wrstb), 32'h0);
    check({tag, "_ym_bus"},    32'({bus_if.ym_bdir, bus_if.ym_bc1}), 32'h0);
    check({tag, "_ym_cs_n"},   32'(bus_if.ym_cs_n), 32'h3);
    check({tag, "_saa"},       32'({bus_if.saa_cs_n, bus_if.saa_wr_n, bus_if.saa_a0}), 32'h6);
    check({tag, "_rd_oe"},     32'(bus_if.rd_oe), 32'h0);
    check({tag, "_state"},     32'(state_dbg), 32'(IDLE));
  endtask

  // Reference model: the one bus event a Z80 I/O cycle must produce.
  // kind: 0 read, 1 write, 2 interrupt acknowledge (m1_n low)
  task automatic model_push(input int kind, input logic [2:0] addr, input logic [7:0] dat,
                            input bit ysel, input bit ssel, input int hold);
    bit a15, a14, a1, port_ok;
    {a15, a14, a1} = addr;
    port_ok = (kind != 2) && a15 && !a1;
    if (!port_ok) return;
    if (kind == 1) begin
      if (a14 && dat[7:4] == 4'hF)
        exp_q.push_back(mk(2'd0, 2'b11, 2'b00, dat, 1, 0));
      else if (ssel)
        exp_q.push_back(mk(2'd2, 2'b11, {1'b0, a14}, dat, 2 + N, N));
      else
        exp_q.push_back(mk(2'd1, ysel ? 2'b01 : 2'b10, a14 ? 2'b11 : 2'b10, dat, 2 + N, N));
    end else begin
      exp_q.push_back(mk(2'd3, ysel ? 2'b01 : 2'b10, 2'b01, 8'h00, hold, 0));
    end
  endtask

  // ---------------- driver ----------------
  task automatic z80_io(input int kind, input logic [2:0] addr, input logic [7:0] dat,
                        input bit ysel, input bit ssel, input int hold, input int gap);
    model_push(kind, addr, dat, ysel, ssel, hold);
    @(posedge clk); #1;
    {bus_if.a15, bus_if.a14, bus_if.a1} = addr;
    bus_if.d       = dat;
    bus_if.ym_sel  = ysel;
    bus_if.saa_sel = ssel;
    bus_if.iorq_n  = 1'b0;
    bus_if.m1_n    = (kind == 2) ? 1'b0 : 1'b1;
    bus_if.wr_n    = (kind == 1) ? 1'b0 : 1'b1;
    bus_if.rd_n    = (kind == 0) ? 1'b0 : 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      // Selects moving after the cycle is latched must not matter
      if (i == 4) begin
        bus_if.ym_sel  = 1'($urandom_range(0, 1));
        bus_if.saa_sel = 1'($urandom_range(0, 1));
      end
    end
    bus_if.iorq_n = 1'b1;
    bus_if.wr_n   = 1'b1;
    bus_if.rd_n   = 1'b1;
    bus_if.m1_n   = 1'b1;
    repeat (gap) @(posedge clk);
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit         act;
  int         cs_len, strb_len, cfg_len;
  bit         rd_seen, saa_seen;
  logic [1:0] cs_pat, bus_pat;
  logic [7:0] data_seen, cfg_seen;

  task automatic emit(input logic [W-1:0] got);
    logic [W-1:0] exp;
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL unexpected_event: got %h expected none", got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL bus_event: got %h expected %h", got, exp);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      act     = 1'b0;
      cfg_len = 0;
    end else begin
      if (bus_if.cfg_wrstb) begin
        cfg_len++;
        cfg_seen = bus_if.cfg_d;
      end else if (cfg_len > 0) begin
        emit(mk(2'd0, 2'b11, 2'b00, cfg_seen, cfg_len, 0));
        cfg_len = 0;
      end

      if (bus_if.ym_cs_n != 2'b11 || !bus_if.saa_cs_n) begin
        if (!act) begin
          act       = 1'b1;
          cs_len    = 0;
          strb_len  = 0;
          rd_seen   = 1'b0;
          saa_seen  = !bus_if.saa_cs_n;
          cs_pat    = bus_if.ym_cs_n;
          bus_pat   = 2'b00;
          data_seen = bus_if.chip_d;
        end
        cs_len++;
        if (bus_if.ym_bdir || !bus_if.saa_wr_n) begin
          strb_len++;
          bus_pat = saa_seen ? {1'b0, bus_if.saa_a0} : {bus_if.ym_bdir, bus_if.ym_bc1};
        end
        if (bus_if.rd_oe) begin
          rd_seen = 1'b1;
          bus_pat = {bus_if.ym_bdir, bus_if.ym_bc1};
        end
      end else if (act) begin
        act = 1'b0;
        if (rd_seen)
          emit(mk(2'd3, cs_pat, bus_pat, 8'h00, cs_len, strb_len));
        else
          emit(mk(saa_seen ? 2'd2 : 2'd1, cs_pat, bus_pat, data_seen, cs_len, strb_len));
      end
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [2:0] P_FFFD = 3'b110;
  localparam logic [2:0] P_BFFD = 3'b100;

  initial begin
    int kind, hold, gap, psel;
    logic [2:0] addr;
    logic [7:0] dat;

    bus_if.iorq_n = 1'b1; bus_if.wr_n = 1'b1; bus_if.rd_n = 1'b1; bus_if.m1_n = 1'b1;
    bus_if.a15 = 1'b0; bus_if.a14 = 1'b0; bus_if.a1 = 1'b0; bus_if.d = 8'h00;
    bus_if.ym_sel = 1'b0; bus_if.saa_sel = 1'b0;

    repeat (3) @(posedge clk); #1;
    check_reset_values("reset");
    @(negedge clk); rst_n = 1'b1;
    repeat (6) @(posedge clk);

    // Directed cases
    z80_io(1, P_FFFD, 8'hF2, 1'b0, 1'b0, 6, 10);   // config write
    z80_io(1, P_FFFD, 8'h07, 1'b0, 1'b0, 6, 10);   // YM0 address
    z80_io(1, P_BFFD, 8'h38, 1'b0, 1'b0, 6, 10);   // YM0 data
    z80_io(1, P_FFFD, 8'h1C, 1'b0, 1'b1, 6, 10);   // SAA address
    z80_io(1, P_BFFD, 8'h01, 1'b0, 1'b1, 6, 10);   // SAA data
    z80_io(0, P_FFFD, 8'h00, 1'b1, 1'b0, 12, 10);  // YM1 read
    z80_io(2, P_FFFD, 8'h07, 1'b0, 1'b0, 6, 10);   // interrupt ack: ignored
    z80_io(1, P_FFFD, 8'h0E, 1'b1, 1'b0, 3, 10);   // short iorq: write still completes
    z80_io(0, P_BFFD, 8'h00, 1'b0, 1'b1, 5, 10);   // #BFFD read with SAA selected -> YM
    z80_io(1, 3'b010, 8'h55, 1'b0, 1'b0, 6, 10);   // non-AY port: ignored

    // Reset in the middle of STRB, released while iorq_n is still low
    @(posedge clk); #1;
    {bus_if.a15, bus_if.a14, bus_if.a1} = P_FFFD;
    bus_if.d = 8'h07; bus_if.ym_sel = 1'b0; bus_if.saa_sel = 1'b0;
    bus_if.iorq_n = 1'b0; bus_if.wr_n = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_values("midreset");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (12) @(posedge clk); #1;
    check("stale_cycle_state", 32'(state_dbg), 32'(IDLE));
    check("stale_cycle_cs", 32'({bus_if.ym_cs_n, bus_if.saa_cs_n}), 32'h7);
    bus_if.iorq_n = 1'b1; bus_if.wr_n = 1'b1;
    repeat (10) @(posedge clk);
    z80_io(1, P_BFFD, 8'hA5, 1'b1, 1'b0, 6, 10);   // next cycle runs normally

    // Randomized cycles
    for (int n = 0; n < 60; n++) begin
      kind = ($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1));
      psel = $urandom_range(0, 4);
      addr = (psel < 2) ? P_FFFD : (psel < 4) ? P_BFFD : 3'($urandom_range(0, 7));
      dat  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 2) == 0) dat[7:4] = 4'hF;
      hold = $urandom_range(3, 12);
      gap  = $urandom_range(8, 14);
      z80_io(kind, addr, dat, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), hold, gap);
    end

    for (int t = 0; t < 200 && exp_q.size() > 0; t++) @(posedge clk);
    while (exp_q.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL missing_event: got none expected %h", exp_q.pop_front());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
